// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter: output-stage state encoding
// and default widths.
package wb_arb_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } wb_state_e;

    localparam int unsigned DEF_AW    = 5;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/mux2_32.sv
// 32-bit 2:1 data select used on the writeback data path.
module mux2_32 (
    input  logic [31:0] I0,
    input  logic [31:0] I1,
    input  logic        sel,
    output logic [31:0] out
);

    assign out = sel ? I1 : I0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester writeback arbiter for the register-file write port. It has a
// one-entry registered output stage and saturating per-requester grant counters.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [31:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [AW-1:0]    out_addr,
    output logic [31:0]      out_data,
    output logic             out_src,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    wb_state_e     state_q, state_d;
    logic          last_grant_q;
    logic          grant;
    logic          can_load;
    logic          accept;
    logic [31:0]   sel_data;
    logic [AW-1:0] sel_addr;

    // Grant depends only on valids and the pointer, never on addr/data.
    always_comb begin
        grant = 1'b0;
        if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req1_valid && req0_valid && FIXED_PRIO == 0) begin
            grant = ~last_grant_q;
        end
    end

    assign can_load   = (state_q == S_EMPTY) || out_ready;
    assign req0_ready = rst_n && can_load && !grant && req0_valid;
    assign req1_ready = rst_n && can_load && grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = S_FULL;
        end else if (out_ready) begin
            state_d = S_EMPTY;
        end
    end

    mux2_32 u_data_mux (
        .I0  (req0_data),
        .I1  (req1_data),
        .sel (grant),
        .out (sel_data)
    );

    assign sel_addr = grant ? req1_addr : req0_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            last_grant_q <= 1'b1;
            out_addr     <= '0;
            out_data     <= '0;
            out_src      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_addr     <= sel_addr;
                out_data     <= sel_data;
                out_src      <= grant;
                last_grant_q <= grant;
            end
        end
    end

    // Clear takes priority over a coincident accept.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (req0_ready && gnt_cnt0 != CNT_MAX) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (req1_ready && gnt_cnt1 != CNT_MAX) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end

    assign out_valid = (state_q == S_FULL);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a round-robin instance and a fixed-priority,
// 2-bit-counter instance share stimulus and are checked against a transaction model.
module tb_wb_port_arbiter;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v0, v1, out_ready, clr_cnt;
    logic [AW-1:0] a0, a1;
    logic [31:0]   d0, d1;

    logic          rdy0 [2];
    logic          rdy1 [2];
    logic          ov   [2];
    logic [AW-1:0] oa   [2];
    logic [31:0]   od   [2];
    logic          os   [2];
    logic [15:0]   c0_a, c1_a;
    logic [1:0]    c0_b, c1_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance
    int          fp      [2] = '{0, 1};
    int          cnt_max [2] = '{65535, 3};
    bit          m_full  [2];
    int unsigned m_addr  [2];
    int unsigned m_data  [2];
    int          m_src   [2];
    int          m_last  [2];
    int          m_cnt0  [2];
    int          m_cnt1  [2];

    always #5 clk = ~clk;

    wb_port_arbiter #(.AW(AW), .CNT_W(16), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1[0]),
        .out_valid(ov[0]), .out_addr(oa[0]), .out_data(od[0]), .out_src(os[0]),
        .out_ready(out_ready), .clr_cnt(clr_cnt), .gnt_cnt0(c0_a), .gnt_cnt1(c1_a)
    );

    wb_port_arbiter #(.AW(AW), .CNT_W(2), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1[1]),
        .out_valid(ov[1]), .out_addr(oa[1]), .out_data(od[1]), .out_src(os[1]),
        .out_ready(out_ready), .clr_cnt(clr_cnt), .gnt_cnt0(c0_b), .gnt_cnt1(c1_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner by the arbitration rules; -1 when nobody requests.
    function automatic int winner(input int i);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (!v0 && !v1) return -1;
        if (fp[i] != 0) return 0;
        return 1 - m_last[i];
    endfunction

    function automatic bit exp_ready(input int i, input int n);
        return rst_n && (!m_full[i] || out_ready) && winner(i) == n;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit acc0 = exp_ready(i, 0);
            bit acc1 = exp_ready(i, 1);
            if (!rst_n) begin
                m_full[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_src[i] = 0;
                m_last[i] = 1; m_cnt0[i] = 0; m_cnt1[i] = 0;
            end else begin
                if (acc0 || acc1) begin
                    m_full[i] = 1;
                    m_addr[i] = acc1 ? int'(a1) : int'(a0);
                    m_data[i] = acc1 ? d1 : d0;
                    m_src[i]  = acc1 ? 1 : 0;
                    m_last[i] = m_src[i];
                end else if (out_ready) begin
                    m_full[i] = 0;
                end
                if (clr_cnt) begin
                    m_cnt0[i] = 0; m_cnt1[i] = 0;
                end else begin
                    if (acc0 && m_cnt0[i] < cnt_max[i]) m_cnt0[i]++;
                    if (acc1 && m_cnt1[i] < cnt_max[i]) m_cnt1[i]++;
                end
            end
        end
    endtask

    // Entered just after a negedge with inputs set; leaves at the next negedge.
    task automatic run_cycle();
        logic [15:0] c0 [2];
        logic [15:0] c1 [2];
        #1;
        c0[0] = c0_a; c0[1] = {14'b0, c0_b};
        c1[0] = c1_a; c1[1] = {14'b0, c1_b};
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rdy0[%0d]", i), rdy0[i], exp_ready(i, 0));
            check($sformatf("rdy1[%0d]", i), rdy1[i], exp_ready(i, 1));
            check($sformatf("out_valid[%0d]", i), ov[i], m_full[i]);
            check($sformatf("out_addr[%0d]", i), oa[i], m_addr[i]);
            check($sformatf("out_data[%0d]", i), od[i], m_data[i]);
            check($sformatf("out_src[%0d]", i), os[i], m_src[i]);
            check($sformatf("cnt0[%0d]", i), c0[i], m_cnt0[i]);
            check($sformatf("cnt1[%0d]", i), c1[i], m_cnt1[i]);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 0; v0 = 1; v1 = 1; a0 = 5'd1; a1 = 5'd2;
        d0 = 32'h1111_0000; d1 = 32'h2222_0000; out_ready = 0; clr_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_src[i] = 0;
            m_last[i] = 1; m_cnt0[i] = 0; m_cnt1[i] = 0;
        end
        @(negedge clk);

        // Reset held with both valids high
        repeat (3) run_cycle();
        #1;
        check("rst_rdy0", rdy0[0], 1'b0);
        check("rst_rdy1", rdy1[0], 1'b0);
        check("rst_out_valid", ov[0], 1'b0);
        check("rst_cnt0", c0_a, 16'd0);
        rst_n = 1;
        #1;
        check("first_tie_rdy0", rdy0[0], 1'b1);
        check("first_tie_rdy1", rdy1[0], 1'b0);
        out_ready = 1;
        run_cycle();

        // Single requester 1
        v0 = 0; v1 = 0; clr_cnt = 1;
        run_cycle();
        clr_cnt = 0; v1 = 1; a1 = 5'd7; d1 = 32'hDEADBEEF;
        #1;
        check("single_rdy1", rdy1[0], 1'b1);
        run_cycle();
        v1 = 0;
        #1;
        check("single_valid", ov[0], 1'b1);
        check("single_addr", oa[0], 5'd7);
        check("single_data", od[0], 32'hDEADBEEF);
        check("single_src", os[0], 1'b1);
        check("single_cnt1", c1_a, 16'd1);
        clr_cnt = 1;
        run_cycle();
        clr_cnt = 0;

        // Round-robin contention
        v0 = 1; v1 = 1;
        for (int k = 0; k < 6; k++) begin
            d0 = 32'hA000_0000 + k; d1 = 32'hB000_0000 + k;
            a0 = 5'(k); a1 = 5'(k + 16);
            #1;
            check("rr_rdy0", rdy0[0], (k % 2) == 0);
            check("rr_rdy1", rdy1[0], (k % 2) == 1);
            check("fp_rdy0", rdy0[1], 1'b1);
            check("fp_rdy1", rdy1[1], 1'b0);
            if (k > 0) check("rr_out_valid", ov[0], 1'b1);
            run_cycle();
        end
        check("rr_cnt0", c0_a, 16'd3);
        check("rr_cnt1", c1_a, 16'd3);
        check("fp_cnt_sat", c0_b, 2'd3);

        // Backpressure with requester 0 waiting
        v1 = 0; out_ready = 0; d0 = 32'hC0FFEE00;
        held = od[0];
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_rdy0", rdy0[0], 1'b0);
            check("bp_data_stable", od[0], held);
            run_cycle();
        end
        out_ready = 1;
        #1;
        check("bp_release_rdy0", rdy0[0], 1'b1);
        run_cycle();

        // Clear wins over a coincident accept
        clr_cnt = 1;
        run_cycle();
        clr_cnt = 0;
        #1;
        check("clr_vs_accept", c0_a, 16'd0);

        // Saturation on the 2-bit instance
        for (int k = 0; k < 5; k++) run_cycle();
        check("sat_cnt0", c0_b, 2'd3);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst_n     = ($urandom_range(99) >= 2);
            v0        = ($urandom_range(9) < 6);
            v1        = ($urandom_range(9) < 6);
            a0        = 5'($urandom);
            a1        = 5'($urandom);
            d0        = $urandom;
            d1        = $urandom;
            out_ready = ($urandom_range(9) < 7);
            clr_cnt   = ($urandom_range(99) < 3);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters, requester 0 and requester 1, for example the ALU/load path and a multi-cycle unit.
- Arbitrates round-robin and accepts each request with a valid/ready handshake.
- Steers the winning data through a 32-bit 2:1 select and presents it on a one-entry registered output stage.
- Keeps saturating per-requester grant counters for performance monitoring.

Parameters:
- AW, 5, register address width.
- CNT_W, 16, width of each grant counter.
- FIXED_PRIO, 0. Value 1 means requester 0 always wins ties. Value 0 means round-robin.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  AW  requester 0 destination register.
- req0_data  in  32  requester 0 write data.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  AW  requester 1 destination register.
- req1_data  in  32  requester 1 write data.
- req1_ready  out  1  requester 1 accepted this cycle.
- out_valid  out  1  output stage holds a write.
- out_addr  out  AW  write address.
- out_data  out  32  write data.
- out_src  out  1  which requester produced the held write.
- out_ready  in  1  consumer takes the held write this cycle.
- clr_cnt  in  1  clear both grant counters.
- gnt_cnt0  out  CNT_W  grants issued to requester 0.
- gnt_cnt1  out  CNT_W  grants issued to requester 1.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Reset is synchronous and active-low via rst_n. It is sampled only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_addr=0, out_data=0, out_src=0.
  - gnt_cnt0=0, gnt_cnt1=0.
  - last_grant=1, so requester 0 wins the first tie.
  - FSM in S_EMPTY.
  - While rst_n=0, req0_ready=0 and req1_ready=0.
- FSM with two states:
  - S_EMPTY: out_valid=0.
  - S_FULL: out_valid=1.
  - can_load = (state==S_EMPTY) | out_ready. Computed combinationally.
- Arbitration (combinational, same cycle):
  - Only requester 0 valid: grant 0.
  - Only requester 1 valid: grant 1.
  - Both valid with FIXED_PRIO=1: grant 0.
  - Both valid with FIXED_PRIO=0: grant = ~last_grant.
  - reqN_ready = can_load & grant==N & reqN_valid.
  - At most one ready is high per cycle.
  - Ready must not depend on reqN_data or reqN_addr.
- Transfer happens when reqN_valid & reqN_ready. On that clock edge:
  - out_data and out_addr load the selected requester's data and address. The data select is driven by grant.
  - out_src <= N and last_grant <= N.
  - FSM moves to S_FULL.
  - Latency is 1 cycle from accept to out_valid.
- In S_FULL:
  - With out_ready=1 and a transfer in the same cycle: stays in S_FULL with the new contents. This gives back-to-back throughput of 1 write/cycle.
  - With out_ready=1 and no transfer: goes to S_EMPTY. out_data and out_addr keep their last values.
  - With out_ready=0: holds everything stable and both readies are 0.
- Handshake rules:
  - A requester keeps valid, addr and data stable until accepted. The block does not check this.
  - The ungranted requester sees ready=0 and waits.
  - Under round-robin, a continuously valid requester is granted within 2 accepts.
- out_ready while out_valid=0: ignored.
- Counters:
  - On each accept, gnt_cntN increments and saturates at 2^CNT_W-1. It never wraps.
  - clr_cnt=1 clears both counters to 0. If an accept happens in the same cycle, clear wins and the result is 0, not 1.
  - clr_cnt does not affect the datapath.
- Reset asserted mid-operation: a held write is dropped (out_valid=0 next edge). The arbitration pointer returns to last_grant=1.

Decomposition:
- Shared package wb_arb_pkg holds:
  - State encodings S_EMPTY=1'b0, S_FULL=1'b1.
  - Default AW=5 and CNT_W=16.
- Sub-module: the existing mux2_32 (ports I0, I1, sel, out) does the data select.
  - I0=req0_data, I1=req1_data, sel=grant.
  - Its output feeds the out_data register.
- The address select is a separate AW-bit 2:1 select inside the block.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles with both valids high.
  - Required: both readies are 0, out_valid=0, counters are 0. The first cycle after release grants requester 0.
- Single requester:
  - Stimulus: req1 only, addr=5'd7, data=32'hDEADBEEF, out_ready=1.
  - Required: req1_ready=1 in cycle 0. Next cycle out_valid=1, out_addr=7, out_data=DEADBEEF, out_src=1. gnt_cnt1=1.
- Contention, round-robin:
  - Stimulus: both requesters continuously valid with distinct data, out_ready=1, for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1, with out_valid high every cycle after the first. gnt_cnt0=3, gnt_cnt1=3.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles while out_valid=1 and requester 0 is valid.
  - Required: req0_ready=0 and outputs are stable. On the first out_ready=1 cycle, requester 0 is accepted the same cycle.
- FIXED_PRIO=1:
  - Stimulus: both requesters valid for 4 cycles.
  - Required: requester 0 is granted all 4 and requester 1 is never ready.
- Counter edges:
  - Stimulus: CNT_W=2 and 5 grants to requester 0.
  - Required: gnt_cnt0 saturates at 3.
  - Stimulus: clr_cnt together with an accept.
  - Required: gnt_cnt0=0 the next cycle.
